iir_channel_scheduler: RTL and testbench

- Time-shares one first-order IIR datapath, y = y_1/4 + x/2, between NCH independent sample streams.
- Holds one y_1 state register per channel.
- Arbitrates requesters round-robin and accepts at most one sample per cycle.
- Emits each filtered result tagged with its channel number, using a valid/ready output handshake.

---
 rtl/iir_channel_scheduler.sv | 109 ++++++++++
 tb/tb_iir_channel_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/iir_channel_scheduler.sv
// Round-robin scheduler sharing one first-order IIR (y = y_1/4 + x/2) across NCH channels.
// Define IIR_ROUND_EN to round both terms instead of truncating.

module iir_lane #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    input  logic         clr,
    input  logic         grant,
    output logic [W-1:0] nxt
);
    logic [W-1:0] state;
    logic [W-1:0] s;

    assign s = clr ? '0 : state;

`ifdef IIR_ROUND_EN
    localparam logic [W:0] TWO = (W+1)'(2);
    localparam logic [W:0] ONE = (W+1)'(1);
    logic [W:0] s_rnd;
    logic [W:0] x_rnd;

    // Widened by one bit so the rounding increment cannot wrap.
    assign s_rnd = {1'b0, s} + TWO;
    assign x_rnd = {1'b0, x} + ONE;
    assign nxt   = W'(s_rnd >> 2) + W'(x_rnd >> 1);
`else
    assign nxt = (s >> 2) + (x >> 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        state <= '0;
        else if (grant) state <= nxt;
        else if (clr)   state <= '0;
    end
endmodule

module iir_channel_scheduler #(
    parameter int NCH = 4,
    parameter int W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          req_valid,
    input  logic [NCH*W-1:0]        req_x,
    output logic [NCH-1:0]          req_ready,
    input  logic [NCH-1:0]          clr,
    output logic [W-1:0]            y,
    output logic [$clog2(NCH)-1:0]  y_ch,
    output logic                    y_valid,
    input  logic                    y_ready
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0][W-1:0] lane_nxt;
    logic [NCH-1:0]        grant;
    logic [CW-1:0]         g;
    logic [CW-1:0]         rr_ptr;
    logic                  accept;
    logic                  free;

    assign free      = !y_valid || y_ready;
    assign req_ready = grant;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        iir_lane #(.W(W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .x     (req_x[i*W +: W]),
            .clr   (clr[i]),
            .grant (grant[i]),
            .nxt   (lane_nxt[i])
        );
    end

    // First requester at or after rr_ptr wins; NCH need not be a power of two.
    always_comb begin
        grant  = '0;
        g      = '0;
        accept = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NCH;
            if (!accept && free && req_valid[idx]) begin
                accept     = 1'b1;
                g          = CW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
            rr_ptr  <= '0;
        end else if (accept) begin
            y       <= lane_nxt[g];
            y_ch    <= g;
            y_valid <= 1'b1;
            rr_ptr  <= (g == CW'(NCH-1)) ? '0 : g + CW'(1);
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Directed bench for iir_channel_scheduler (default truncating build, NCH=4, W=4).
module tb_iir_channel_scheduler;
    localparam int NCH = 4;
    localparam int W   = 4;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH*W-1:0]  req_x = '0;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    clr = '0;
    logic [W-1:0]      y;
    logic [CW-1:0]     y_ch;
    logic              y_valid;
    logic              y_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    iir_channel_scheduler #(.NCH(NCH), .W(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x),
        .req_ready(req_ready), .clr(clr), .y(y), .y_ch(y_ch),
        .y_valid(y_valid), .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0; req_x = '0; clr = '0; y_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One cycle with only channel ch requesting.
    task automatic feed(input int ch, input logic [W-1:0] x, input logic [NCH-1:0] c);
        req_valid = '0;
        req_valid[ch] = 1'b1;
        req_x[ch*W +: W] = x;
        clr = c;
        tick();
        req_valid = '0;
        clr = '0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if (y !== 4'd0)       begin fails++; $display("FAIL reset_y got %0d exp 0", y); end
        tests++; if (y_ch !== 2'd0)    begin fails++; $display("FAIL reset_ych got %0d exp 0", y_ch); end
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL reset_yvalid got %b exp 0", y_valid); end
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    endtask

    task automatic test_single();
        logic [W-1:0] xs [5] = '{4'd8, 4'd8, 4'd8, 4'd15, 4'd15};
        logic [W-1:0] ex [5] = '{4'd4, 4'd5, 4'd5, 4'd8, 4'd9};
        do_reset();
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            req_x[3:0] = xs[i];
            #1;
            tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready[%0d] got %b exp 0001", i, req_ready); end
            tick();
            tests++; if (y !== ex[i] || y_ch !== 2'd0 || y_valid !== 1'b1) begin
                fails++; $display("FAIL single_y[%0d] got y=%0d ch=%0d v=%b exp y=%0d ch=0 v=1", i, y, y_ch, y_valid, ex[i]);
            end
        end
        req_valid = '0;
        tick();
        tests++; if (y_valid !== 1'b0 || y !== 4'd9) begin
            fails++; $display("FAIL single_idle got y=%0d v=%b exp y=9 v=0", y, y_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            tests++; if (req_ready !== (4'b0001 << (k % 4))) begin
                fails++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'b0001 << (k % 4));
            end
            tick();
            tests++; if (y_ch !== 2'(k % 4) || y_valid !== 1'b1) begin
                fails++; $display("FAIL rr_ych[%0d] got ch=%0d v=%b exp ch=%0d v=1", k, y_ch, y_valid, k % 4);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0100;
        req_x[8 +: 4] = 4'd6;
        tick();
        tests++; if (y !== 4'd3 || y_ch !== 2'd2 || y_valid !== 1'b1) begin
            fails++; $display("FAIL bp_first got y=%0d ch=%0d v=%b exp y=3 ch=2 v=1", y, y_ch, y_valid);
        end
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, req_ready); end
            tick();
            tests++; if (y !== 4'd3 || y_ch !== 2'd2 || y_valid !== 1'b1) begin
                fails++; $display("FAIL bp_hold[%0d] got y=%0d ch=%0d v=%b exp y=3 ch=2 v=1", i, y, y_ch, y_valid);
            end
        end
        y_ready = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready got %b exp 0100", req_ready); end
        tick();
        tests++; if (y !== 4'd3 || y_ch !== 2'd2 || y_valid !== 1'b1) begin
            fails++; $display("FAIL bp_release got y=%0d ch=%0d v=%b exp y=3 ch=2 v=1", y, y_ch, y_valid);
        end
        req_valid = '0;
    endtask

    task automatic test_clear();
        int           chs [4] = '{3, 0, 2, 1};
        logic [W-1:0] ex  [4] = '{4'd0, 4'd1, 4'd1, 4'd0};
        do_reset();
        feed(0, 4'd8, '0);
        feed(2, 4'd14, '0);
        feed(3, 4'd14, '0);
        feed(1, 4'd15, '0);
        feed(1, 4'd15, '0);
        feed(1, 4'd15, '0);
        // 9 is the largest state a 4-bit channel can reach.
        tests++; if (y !== 4'd9) begin fails++; $display("FAIL clr_setup got %0d exp 9", y); end
        feed(1, 4'd4, 4'b0010);
        tests++; if (y !== 4'd2 || y_ch !== 2'd1) begin fails++; $display("FAIL clr_grant got y=%0d ch=%0d exp y=2 ch=1", y, y_ch); end
        feed(1, 4'd4, '0);
        tests++; if (y !== 4'd2) begin fails++; $display("FAIL clr_after got %0d exp 2", y); end
        clr = 4'b1000;
        tick();
        clr = '0;
        tests++; if (y !== 4'd2 || y_valid !== 1'b0) begin
            fails++; $display("FAIL clr_idle got y=%0d v=%b exp y=2 v=0", y, y_valid);
        end
        for (int i = 0; i < 4; i++) begin
            feed(chs[i], 4'd0, '0);
            tests++; if (y !== ex[i] || y_ch !== 2'(chs[i])) begin
                fails++; $display("FAIL clr_state[ch%0d] got y=%0d ch=%0d exp y=%0d", chs[i], y, y_ch, ex[i]);
            end
        end
    endtask

    task automatic test_priority();
        do_reset();
        feed(0, 4'd0, '0);
        req_valid = 4'b1001;
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL prio_first got %b exp 1000", req_ready); end
        tick();
        tests++; if (y_ch !== 2'd3) begin fails++; $display("FAIL prio_ych3 got %0d exp 3", y_ch); end
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL prio_second got %b exp 0001", req_ready); end
        tick();
        tests++; if (y_ch !== 2'd0) begin fails++; $display("FAIL prio_ych0 got %0d exp 0", y_ch); end
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL prio_solo[%0d] got %b exp 0001", i, req_ready); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        feed(0, 4'd8, '0);
        feed(0, 4'd8, '0);
        tests++; if (y !== 4'd5 || y_valid !== 1'b1) begin fails++; $display("FAIL ar_pre got y=%0d v=%b exp y=5 v=1", y, y_valid); end
        req_valid = 4'b1111;
        y_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++; if (y_valid !== 1'b0 || y !== 4'd0 || y_ch !== 2'd0) begin
            fails++; $display("FAIL ar_async got y=%0d ch=%0d v=%b exp 0 0 0", y, y_ch, y_valid);
        end
        tick();
        rst = 1'b0;
        y_ready = 1'b1;
        req_valid = '0;
        feed(0, 4'd8, '0);
        tests++; if (y !== 4'd4 || y_ch !== 2'd0 || y_valid !== 1'b1) begin
            fails++; $display("FAIL ar_after got y=%0d ch=%0d v=%b exp y=4 ch=0 v=1", y, y_ch, y_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_clear();
        test_priority();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
